bcd_updown_counter: RTL
=======================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of cascaded BCD decades, legal range 1..8.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Cin  input  1  count enable; one step per cycle while high.
REQ-005 Dir  input  1  count direction; 1 = up, 0 = down; sampled with Cin.
REQ-006 Clr  input  1  synchronous clear to zero.
REQ-007 Load  input  1  synchronous parallel load of Din.
REQ-008 Din  input  4*DIGITS  load value, packed BCD, digit 0 in bits [3:0].
REQ-009 q  output  4*DIGITS  current count, packed BCD, digit 0 in bits [3:0].
REQ-010 Cout  output  1  registered up-wrap pulse.
REQ-011 Bout  output  1  registered down-wrap pulse.
REQ-012 Zero  output  1  combinational, high when q is all zero.

Function
REQ-013 Priority per cycle SHALL be Clr > Load > Cin; Cin low with no Clr/Load holds q.
REQ-014 Up step: digit 0 increments; a digit at 9 with carry-in goes to 0 and carries to the next digit.
REQ-015 Down step: digit 0 decrements; a digit at 0 with borrow-in goes to 9 and borrows from the next digit.
REQ-016 Carry/borrow ripple across all digits SHALL resolve in the same cycle (single-cycle step latency, q updates on the edge after Cin sampled high).
REQ-017 Up wrap: all digits 9, Cin=1, Dir=1 -> q becomes all 0 and Cout=1 for exactly that next cycle.
REQ-018 Down wrap: all digits 0, Cin=1, Dir=0 -> q becomes all 9 and Bout=1 for exactly that next cycle.
REQ-019 Cout and Bout SHALL be 0 in every cycle not following a wrap step, including cycles after Clr or Load.
REQ-020 Cout and Bout SHALL never be high in the same cycle.
REQ-021 Load: any Din digit greater than 9 SHALL be loaded as 9; legal digits load unchanged.
REQ-022 Clr and Load high together: Clr wins, q becomes all 0, Cout=Bout=0.
REQ-023 Dir change between consecutive Cin cycles SHALL take effect on the next step with no idle cycle.
REQ-024 Zero SHALL follow q combinationally, including during reset.
REQ-025 q SHALL never hold a non-BCD digit value.

Reset
REQ-026 Rst_n low SHALL immediately force q to all 0, Cout=0, Bout=0, hence Zero=1.
REQ-027 Reset asserted mid-count SHALL discard the in-flight step; no Cout/Bout pulse is produced on release.
REQ-028 After Rst_n deasserts, the first step occurs on the first rising edge with Cin=1.

Structure
REQ-029 Shared package bcd_pkg SHALL hold the 4-bit digit typedef and constants BCD_MAX (9) and BCD_MIN (0).
REQ-030 One sub-module bcd_digit SHALL implement a single decade: registered digit, combinational enable-in/dir/carry-out/borrow-out, clear, load with clamp.
REQ-031 Top level SHALL instantiate DIGITS bcd_digit cells in a generate loop, chain carry/borrow, and register Cout/Bout.

Verification (DIGITS=2)
REQ-032 Load 98, Dir=1, Cin=1 two cycles -> q=99 then q=00 with Cout=1 in the 00 cycle only.
REQ-033 Clr, Dir=0, Cin=1 one cycle -> q=99, Bout=1 one cycle, Cout=0, Zero 1->0.
REQ-034 Load Din=0x4F -> q=49; Load Din=0xA3 -> q=93; no Cout/Bout.
REQ-035 Clr=1 and Load=1 with Din=57 same cycle -> q=00, Zero=1.
REQ-036 Count up from 05, Cin toggled 1,0,1 -> q=06, 06, 07; then Dir=0 -> 06.
REQ-037 Rst_n pulsed low asynchronously with q=99, Cin=1, Dir=1 -> q=00 immediately, Cout stays 0 after release.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, decade limits and the load clamp helper.
package bcd_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;
    localparam digit_t BCD_MIN = 4'd0;

    function automatic digit_t bcd_clamp(input digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: registered digit with clear, clamped load and up/down step.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic   Clk,
    input  logic   Rst_n,
    input  logic   en,
    input  logic   dir,
    input  logic   clr,
    input  logic   load,
    input  digit_t din,
    output digit_t q,
    output logic   carry,
    output logic   borrow
);

    digit_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = BCD_MIN;
        end else if (load) begin
            digit_d = bcd_clamp(din);
        end else if (en) begin
            if (dir) begin
                digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    // Ripple terms stay combinational so the whole chain steps in one cycle.
    assign carry  = en & dir & (digit_q >= BCD_MAX);
    assign borrow = en & ~dir & (digit_q == BCD_MIN);
    assign q      = digit_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded multi-decade BCD up/down counter with registered wrap pulses.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Cin,
    input  logic                  Dir,
    input  logic                  Clr,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Din,
    output logic [4*DIGITS-1:0]   q,
    output logic                  Cout,
    output logic                  Bout,
    output logic                  Zero
);

    logic [DIGITS-1:0] en;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] borrow;
    logic              cout_q, bout_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_first
            assign en[i] = Cin;
        end else begin : g_rest
            assign en[i] = carry[i-1] | borrow[i-1];
        end

        bcd_digit u_digit (
            .Clk    (Clk),
            .Rst_n  (Rst_n),
            .en     (en[i]),
            .dir    (Dir),
            .clr    (Clr),
            .load   (Load),
            .din    (Din[4*i +: 4]),
            .q      (q[4*i +: 4]),
            .carry  (carry[i]),
            .borrow (borrow[i])
        );
    end

    // A ripple out of the top decade is a wrap only when the step actually happens.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cout_q <= 1'b0;
            bout_q <= 1'b0;
        end else begin
            cout_q <= ~Clr & ~Load & carry[DIGITS-1];
            bout_q <= ~Clr & ~Load & borrow[DIGITS-1];
        end
    end

    assign Cout = cout_q;
    assign Bout = bout_q;
    assign Zero = (q == '0);

endmodule
